// File: rtl/mcb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mcb_pkg
//  Purpose  : Shared command encodings, FIFO depths, burst and data widths
//             and the execution-state type for the MCB port-0 responder.
//  Revision : 1.0  initial release
// ============================================================================
package mcb_pkg;

    // Command instruction encodings; anything else is treated as a no-op
    localparam logic [2:0] c_cmd_write    = 3'b000;
    localparam logic [2:0] c_cmd_read     = 3'b001;
    localparam logic [2:0] c_cmd_write_ap = 3'b010;
    localparam logic [2:0] c_cmd_read_ap  = 3'b011;

    // Widths of the user-side buses
    localparam int c_instr_w     = 3;
    localparam int c_bl_w        = 6;
    localparam int c_byte_addr_w = 30;
    localparam int c_data_w      = 128;
    localparam int c_mask_w      = 16;

    // FIFO depths and the occupancy-count width of the data FIFOs (0..64)
    localparam int c_cmd_fifo_depth  = 4;
    localparam int c_data_fifo_depth = 64;
    localparam int c_data_cnt_w      = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_NOP   = 2'd3
    } exec_state_t;

    function automatic logic is_write_cmd(input logic [2:0] instr);
        return (instr == c_cmd_write) || (instr == c_cmd_write_ap);
    endfunction

    function automatic logic is_read_cmd(input logic [2:0] instr);
        return (instr == c_cmd_read) || (instr == c_cmd_read_ap);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock first-word-fall-through FIFO with occupancy count
//             and full/empty flags. Push while full and pop while empty are
//             ignored. DEPTH must be a power of two.
//  Revision : 1.0  initial release
// ============================================================================
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Storage array: written on accepted pushes, no reset needed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop keep the count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mcb_p0_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mcb_p0_responder
//  Purpose  : Behavioural stand-in for one MCB user port. Commands, write
//             data and read data pass through FIFOs; an execution FSM moves
//             bursts between the FIFOs and a byte-maskable backing RAM.
//  Revision : 1.0  initial release
// ============================================================================
module mcb_p0_responder
    import mcb_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int CALIB_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      calib_done,
    input  logic                      cmd_en,
    input  logic [c_instr_w-1:0]      cmd_instr,
    input  logic [c_bl_w-1:0]         cmd_bl,
    input  logic [c_byte_addr_w-1:0]  cmd_byte_addr,
    output logic                      cmd_empty,
    output logic                      cmd_full,
    input  logic                      wr_en,
    input  logic [c_data_w-1:0]       wr_data,
    input  logic [c_mask_w-1:0]       wr_mask,
    output logic                      wr_full,
    output logic                      wr_empty,
    output logic [c_data_cnt_w-1:0]   wr_count,
    output logic                      wr_underrun,
    output logic                      wr_error,
    input  logic                      rd_en,
    output logic [c_data_w-1:0]       rd_data,
    output logic                      rd_full,
    output logic                      rd_empty,
    output logic [c_data_cnt_w-1:0]   rd_count,
    output logic                      rd_error
);

    localparam int CMD_W = c_instr_w + c_bl_w + ADDR_W;
    localparam int WR_W  = c_mask_w + c_data_w;
    localparam int CAL_W = $clog2(CALIB_CYCLES + 1);

    // ---------------- calibration ----------------
    logic [CAL_W-1:0] r_calib_cnt;
    logic             r_calib_done;

    // Count cycles from reset release; ready once CALIB_CYCLES edges have passed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_calib_cnt  <= '0;
            r_calib_done <= 1'b0;
        end else if (!r_calib_done) begin
            r_calib_cnt <= r_calib_cnt + CAL_W'(1);
            if (r_calib_cnt == CAL_W'(CALIB_CYCLES - 1)) begin
                r_calib_done <= 1'b1;
            end
        end
    end

    assign calib_done = r_calib_done;

    // ---------------- FIFOs ----------------
    logic [CMD_W-1:0]        w_cmd_dout;
    logic [2:0]              w_cmd_count;
    logic                    w_cmd_pop;
    logic [c_instr_w-1:0]    w_cmd_instr;
    logic [c_bl_w-1:0]       w_cmd_bl;
    logic [ADDR_W-1:0]       w_cmd_addr;

    logic [WR_W-1:0]         w_wr_dout;
    logic                    w_wr_pop;
    logic [c_data_w-1:0]     w_wr_data;
    logic [c_mask_w-1:0]     w_wr_mask;

    logic [c_data_w-1:0]     r_ram_q;
    logic                    r_ram_vld;

    sync_fifo #(.WIDTH(CMD_W), .DEPTH(c_cmd_fifo_depth)) u_cmd_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (cmd_en),
        .i_din   ({cmd_instr, cmd_bl, cmd_byte_addr[ADDR_W+3:4]}),
        .i_pop   (w_cmd_pop),
        .o_dout  (w_cmd_dout),
        .o_full  (cmd_full),
        .o_empty (cmd_empty),
        .o_count (w_cmd_count)
    );

    sync_fifo #(.WIDTH(WR_W), .DEPTH(c_data_fifo_depth)) u_wr_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (wr_en),
        .i_din   ({wr_mask, wr_data}),
        .i_pop   (w_wr_pop),
        .o_dout  (w_wr_dout),
        .o_full  (wr_full),
        .o_empty (wr_empty),
        .o_count (wr_count)
    );

    sync_fifo #(.WIDTH(c_data_w), .DEPTH(c_data_fifo_depth)) u_rd_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (r_ram_vld),
        .i_din   (r_ram_q),
        .i_pop   (rd_en),
        .o_dout  (rd_data),
        .o_full  (rd_full),
        .o_empty (rd_empty),
        .o_count (rd_count)
    );

    assign w_cmd_instr = w_cmd_dout[CMD_W-1 -: c_instr_w];
    assign w_cmd_bl    = w_cmd_dout[ADDR_W +: c_bl_w];
    assign w_cmd_addr  = w_cmd_dout[ADDR_W-1:0];
    assign w_wr_data   = w_wr_dout[c_data_w-1:0];
    assign w_wr_mask   = w_wr_dout[WR_W-1 -: c_mask_w];

    // ---------------- execution FSM ----------------
    exec_state_t         r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [c_bl_w-1:0]   r_left;
    logic                r_rd_req;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic                r_wr_underrun;
    // Words promised to the rd FIFO by accepted reads but not yet pushed
    logic [c_data_cnt_w-1:0] r_resv;

    logic                    w_cmd_is_rd;
    logic [7:0]              w_need;
    logic                    w_rd_space_ok;
    logic [c_data_cnt_w-1:0] w_resv_add;

    assign w_cmd_is_rd   = is_read_cmd(w_cmd_instr);
    assign w_need        = {2'b00, w_cmd_bl} + 8'd1;
    assign w_rd_space_ok = ({1'b0, rd_count} + {1'b0, r_resv} + w_need) <= 8'd64;
    assign w_cmd_pop     = r_calib_done && (r_state == ST_IDLE) && !cmd_empty &&
                           (!w_cmd_is_rd || w_rd_space_ok);
    assign w_wr_pop      = (r_state == ST_WRITE) && !wr_empty;
    assign w_resv_add    = (w_cmd_pop && w_cmd_is_rd) ? w_need[c_data_cnt_w-1:0] : '0;

    // Command sequencing: dispatch, per-word write/read issue, underrun flagging
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_addr        <= '0;
            r_left        <= '0;
            r_rd_req      <= 1'b0;
            r_rd_addr     <= '0;
            r_wr_underrun <= 1'b0;
            r_resv        <= '0;
        end else begin
            r_rd_req      <= 1'b0;
            r_wr_underrun <= 1'b0;
            r_resv        <= r_resv + w_resv_add - c_data_cnt_w'(r_ram_vld);
            case (r_state)
                ST_IDLE: begin
                    if (w_cmd_pop) begin
                        r_addr <= w_cmd_addr;
                        r_left <= w_cmd_bl;
                        if (is_write_cmd(w_cmd_instr)) begin
                            r_state <= ST_WRITE;
                        end else if (w_cmd_is_rd) begin
                            r_state <= ST_READ;
                        end else begin
                            r_state <= ST_NOP;
                        end
                    end
                end
                ST_WRITE: begin
                    if (w_wr_pop) begin
                        r_addr <= r_addr + ADDR_W'(1);
                        if (r_left == '0) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_left <= r_left - c_bl_w'(1);
                        end
                    end else begin
                        r_wr_underrun <= 1'b1;
                    end
                end
                ST_READ: begin
                    r_rd_req  <= 1'b1;
                    r_rd_addr <= r_addr;
                    r_addr    <= r_addr + ADDR_W'(1);
                    if (r_left == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_left <= r_left - c_bl_w'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign wr_underrun = r_wr_underrun;

    // ---------------- backing RAM ----------------
    logic [c_data_w-1:0] r_ram [1 << ADDR_W];

    // Byte-enabled write (mask bit high keeps the byte) and one-cycle read
    always_ff @(posedge clk) begin
        if (w_wr_pop) begin
            for (int b = 0; b < c_mask_w; b++) begin
                if (!w_wr_mask[b]) begin
                    r_ram[r_addr][b*8 +: 8] <= w_wr_data[b*8 +: 8];
                end
            end
        end
        if (r_rd_req) begin
            r_ram_q <= r_ram[r_rd_addr];
        end
    end

    // Read-data valid tracks the issued request one cycle later
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ram_vld <= 1'b0;
        end else begin
            r_ram_vld <= r_rd_req;
        end
    end

    // ---------------- sticky error flags ----------------
    logic r_wr_error;
    logic r_rd_error;

    // Overflowing push and underflowing pop each latch their flag until reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_error <= 1'b0;
            r_rd_error <= 1'b0;
        end else begin
            if (wr_en && wr_full) begin
                r_wr_error <= 1'b1;
            end
            if (rd_en && rd_empty) begin
                r_rd_error <= 1'b1;
            end
        end
    end

    assign wr_error = r_wr_error;
    assign rd_error = r_rd_error;

endmodule
`default_nettype wire

// File: tb/tb_mcb_p0_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mcb_p0_responder
//  Purpose  : Directed self-checking bench for mcb_p0_responder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mcb_p0_responder;

    logic         clk;
    logic         reset;
    logic         calib_done;
    logic         cmd_en;
    logic [2:0]   cmd_instr;
    logic [5:0]   cmd_bl;
    logic [29:0]  cmd_byte_addr;
    logic         cmd_empty;
    logic         cmd_full;
    logic         wr_en;
    logic [127:0] wr_data;
    logic [15:0]  wr_mask;
    logic         wr_full;
    logic         wr_empty;
    logic [6:0]   wr_count;
    logic         wr_underrun;
    logic         wr_error;
    logic         rd_en;
    logic [127:0] rd_data;
    logic         rd_full;
    logic         rd_empty;
    logic [6:0]   rd_count;
    logic         rd_error;

    mcb_p0_responder #(.ADDR_W(10), .CALIB_CYCLES(16)) u_dut (
        .clk           (clk),
        .reset         (reset),
        .calib_done    (calib_done),
        .cmd_en        (cmd_en),
        .cmd_instr     (cmd_instr),
        .cmd_bl        (cmd_bl),
        .cmd_byte_addr (cmd_byte_addr),
        .cmd_empty     (cmd_empty),
        .cmd_full      (cmd_full),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .wr_mask       (wr_mask),
        .wr_full       (wr_full),
        .wr_empty      (wr_empty),
        .wr_count      (wr_count),
        .wr_underrun   (wr_underrun),
        .wr_error      (wr_error),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rd_full       (rd_full),
        .rd_empty      (rd_empty),
        .rd_count      (rd_count),
        .rd_error      (rd_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference memory and queues: pending write words and expected read words
    logic [127:0] m_mem [1024];
    logic [143:0] m_wq  [$];
    logic [127:0] q_exp [$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_wr(input logic [127:0] d, input logic [15:0] m);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = d;
        wr_mask = m;
        m_wq.push_back({m, d});
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    task automatic send_cmd(input logic [2:0] instr, input logic [5:0] bl, input logic [29:0] addr);
        @(negedge clk);
        cmd_en        = 1'b1;
        cmd_instr     = instr;
        cmd_bl        = bl;
        cmd_byte_addr = addr;
        @(posedge clk);
        #1 cmd_en = 1'b0;
    endtask

    task automatic model_write(input int word, input int n);
        logic [143:0] e;
        for (int i = 0; i < n; i++) begin
            e = m_wq.pop_front();
            for (int b = 0; b < 16; b++) begin
                if (!e[128 + b]) m_mem[(word + i) % 1024][b*8 +: 8] = e[b*8 +: 8];
            end
        end
    endtask

    task automatic exp_read(input int word, input int n);
        for (int i = 0; i < n; i++) q_exp.push_back(m_mem[(word + i) % 1024]);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pop_chk(input string tag);
        int n;
        logic [127:0] e;
        n = 0;
        while (rd_empty && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        if (rd_empty) begin
            chk({tag, "_timeout"}, {127'd0, rd_empty}, 128'd0);
        end else begin
            e = (q_exp.size() > 0) ? q_exp.pop_front() : 'x;
            chk(tag, rd_data, e);
            rd_en = 1'b1;
            @(posedge clk);
            #1 rd_en = 1'b0;
        end
    endtask

    int cyc;
    int peak;

    initial begin
        reset = 1'b1;
        cmd_en = 0; cmd_instr = 0; cmd_bl = 0; cmd_byte_addr = 0;
        wr_en = 0; wr_data = 0; wr_mask = 0; rd_en = 0;
        repeat (3) @(posedge clk);
        #1;
        // calib, cmd_empty, cmd_full, wr_empty, wr_full, rd_empty, rd_full, underrun, wr_err, rd_err
        chk("reset_flags", {calib_done, cmd_empty, cmd_full, wr_empty, wr_full,
                            rd_empty, rd_full, wr_underrun, wr_error, rd_error}, 10'b0101010000);
        chk("reset_counts", {wr_count, rd_count}, 14'd0);

        // Release reset with a write queued before calibration completes
        @(negedge clk);
        reset = 1'b0;
        wr_en = 1'b1; wr_data = 128'h5555; wr_mask = 16'h0000;
        m_wq.push_back({16'h0000, 128'h5555});
        cmd_en = 1'b1; cmd_instr = 3'b000; cmd_bl = 6'd0; cmd_byte_addr = 30'h50;
        cyc = 0;
        while (!calib_done && cyc < 64) begin
            @(posedge clk);
            #1;
            wr_en = 1'b0; cmd_en = 1'b0;
            cyc++;
        end
        chk("calib_latency", cyc, 16);
        chk("pre_calib_held", {cmd_empty, wr_count}, {1'b0, 7'd1});
        model_write(5, 1);
        wait_cycles(4);
        chk("post_calib_exec", {cmd_empty, wr_count}, {1'b1, 7'd0});

        // 16-word burst write then read back at 0x100
        for (int i = 0; i < 16; i++) push_wr(128'(i), 16'h0000);
        send_cmd(3'b000, 6'd15, 30'h100);
        model_write(16, 16);
        send_cmd(3'b001, 6'd15, 30'h100);
        exp_read(16, 16);
        peak = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1 if (int'(rd_count) > peak) peak = int'(rd_count);
        end
        chk("burst_rd_peak", peak, 16);
        for (int i = 0; i < 16; i++) pop_chk($sformatf("burst_rd_%0d", i));

        // Idle read latency: rd_empty drops on the 4th edge after the cmd edge
        send_cmd(3'b001, 6'd0, 30'h130);
        exp_read(19, 1);
        cyc = 0;
        while (rd_empty && cyc < 20) begin
            @(posedge clk);
            #1 cyc++;
        end
        chk("rd_latency", cyc, 4);
        pop_chk("rd_latency_data");

        // Byte mask: zero word 0, then write all-ones keeping the low 8 bytes
        push_wr(128'd0, 16'h0000);
        send_cmd(3'b000, 6'd0, 30'h0);
        push_wr({128{1'b1}}, 16'h00FF);
        send_cmd(3'b010, 6'd0, 30'h0);
        model_write(0, 2);
        send_cmd(3'b011, 6'd0, 30'h0);
        q_exp.push_back(128'hFFFFFFFF_FFFFFFFF_00000000_00000000);
        pop_chk("mask_rd");

        // Wrap-around from the last word, plus ignored upper address bits
        for (int i = 0; i < 4; i++) push_wr(128'hA0 + 128'(i), 16'h0000);
        send_cmd(3'b000, 6'd3, 30'h3FF0);
        model_write(1023, 4);
        send_cmd(3'b001, 6'd3, 30'h3FF0);
        for (int i = 0; i < 4; i++) q_exp.push_back(128'hA0 + 128'(i));
        send_cmd(3'b001, 6'd0, 30'h0);
        q_exp.push_back(128'hA1);
        send_cmd(3'b001, 6'd0, 30'h4010);
        q_exp.push_back(128'hA2);
        for (int i = 0; i < 6; i++) pop_chk($sformatf("wrap_rd_%0d", i));

        // NOP command is consumed without touching the data FIFOs
        send_cmd(3'b111, 6'd5, 30'h0);
        wait_cycles(4);
        chk("nop_consumed", {cmd_empty, rd_empty, wr_empty}, 3'b111);

        // Underrun: 8-word burst with only 4 words supplied up front
        for (int i = 0; i < 4; i++) push_wr(128'hB0 + 128'(i), 16'h0000);
        send_cmd(3'b000, 6'd7, 30'h200);
        wait_cycles(8);
        cyc = 0;
        for (int i = 0; i < 5; i++) begin
            if (wr_underrun) cyc++;
            @(posedge clk);
            #1;
        end
        chk("underrun_pulses", cyc, 5);
        for (int i = 4; i < 8; i++) push_wr(128'hB0 + 128'(i), 16'h0000);
        wait_cycles(3);
        chk("underrun_cleared", {wr_underrun, wr_empty}, 2'b01);
        model_write(32, 8);
        send_cmd(3'b001, 6'd7, 30'h200);
        for (int i = 0; i < 8; i++) q_exp.push_back(128'hB0 + 128'(i));
        for (int i = 0; i < 8; i++) pop_chk($sformatf("underrun_rd_%0d", i));

        // Fill the wr FIFO, overflow it once, then drain into words 64..127
        for (int i = 0; i < 64; i++) push_wr({32'hC0DE, 64'd0, 32'(i)}, 16'h0000);
        chk("wr_full", {wr_full, wr_count, wr_error}, {1'b1, 7'd64, 1'b0});
        @(negedge clk);
        wr_en = 1'b1; wr_data = {128{1'b1}}; wr_mask = 16'h0000;
        @(posedge clk);
        #1 wr_en = 1'b0;
        chk("wr_overflow", {wr_error, wr_count}, {1'b1, 7'd64});
        send_cmd(3'b000, 6'd63, 30'h400);
        model_write(64, 64);
        wait_cycles(70);
        chk("wr_drained", {wr_empty, wr_count}, {1'b1, 7'd0});

        // Read back-pressure: 61 words queued, a 4-word read must wait for space
        send_cmd(3'b001, 6'd60, 30'h400);
        exp_read(64, 61);
        wait_cycles(70);
        chk("rd_fill_61", rd_count, 7'd61);
        send_cmd(3'b001, 6'd3, 30'h400);
        exp_read(64, 4);
        wait_cycles(10);
        chk("rd_cmd_held", {cmd_empty, rd_count}, {1'b0, 7'd61});
        pop_chk("rd_pop_first");
        cyc = 0;
        while (rd_count != 7'd64 && cyc < 20) begin
            @(posedge clk);
            #1 cyc++;
        end
        chk("rd_full_64", {rd_full, rd_count, cmd_empty}, {1'b1, 7'd64, 1'b1});
        for (int i = 0; i < 64; i++) pop_chk($sformatf("drain_rd_%0d", i));
        chk("rd_drained", {rd_empty, rd_error}, 2'b10);

        // Pop while empty sets the sticky read error
        @(negedge clk);
        rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
        wait_cycles(2);
        chk("rd_error_sticky", {rd_error, rd_count}, {1'b1, 7'd0});

        // Reset clears flags and calibration
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("reset_again", {calib_done, wr_error, rd_error, cmd_empty, wr_empty, rd_empty},
                           6'b000111);
        wait_cycles(2);
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
